// File: rtl/uart_rx_bit_timer_pkg.sv
// Shared constants, frame configuration type and frame-length helper for the
// UART receive bit timer.
package uart_rx_bit_timer_pkg;

  localparam int unsigned DATA_BASE        = 5;
  localparam int unsigned MAX_FRAME_LEN    = 12;
  localparam int unsigned MIN_PRESCALE_DEF = 4;

  typedef struct packed {
    logic       par_en;
    logic [1:0] data_len;
    logic       stop2;
  } frame_cfg_t;

  // Start bit + data bits + optional parity + one or two stop bits (7..12).
  function automatic logic [3:0] frame_len(input logic       par_en,
                                           input logic [1:0] data_len,
                                           input logic       stop2);
    logic [3:0] stop_bits;
    stop_bits = stop2 ? 4'd2 : 4'd1;
    return 4'd1 + 4'(DATA_BASE) + {2'b00, data_len} + {3'b000, par_en} + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer_if.sv
// Configuration and timing bundle between the RX FSM/sampler side (master)
// and the bit timer (slave).
interface uart_rx_bit_timer_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);

  logic                  enable;
  logic                  par_en;
  logic [1:0]            data_len;
  logic                  stop2;
  logic [PRESCALE_W-1:0] prescale;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic                  sample_stb;
  logic                  mid_stb;
  logic                  bit_done;
  logic                  frame_done;

  modport master (
    output enable, par_en, data_len, stop2, prescale,
    input  bit_cnt, edge_cnt, sample_stb, mid_stb, bit_done, frame_done
  );

  modport slave (
    input  enable, par_en, data_len, stop2, prescale,
    output bit_cnt, edge_cnt, sample_stb, mid_stb, bit_done, frame_done
  );

endinterface

// File: rtl/uart_rx_bit_timer_edge_counter.sv
// Oversampling edge counter: counts 0..pe-1 per bit and decodes the
// majority-sample, mid-bit and last-edge strobes from the registered count.
module uart_edge_counter #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] pe,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  bit_done,
  output logic                  sample_stb,
  output logic                  mid_stb
);

  logic [PRESCALE_W-1:0] last_edge;
  logic [PRESCALE_W-1:0] half;
  logic                  at_last;
  logic                  at_mid;

  // Strobe decode; pe is never below the clamp minimum, so half-1 cannot underflow.
  always_comb begin
    last_edge  = pe - PRESCALE_W'(1);
    half       = pe >> 1;
    at_last    = (edge_cnt == last_edge);
    at_mid     = (edge_cnt == half);
    bit_done   = enable & at_last;
    mid_stb    = enable & at_mid;
    sample_stb = enable & ((edge_cnt == (half - PRESCALE_W'(1))) | at_mid |
                           (edge_cnt == (half + PRESCALE_W'(1))));
  end

  // Edge counter: clears while disabled, wraps after the last edge of a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
    end else if (at_last) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_bit_timer.sv
// UART receive bit timer: shadows the frame configuration at frame start,
// counts bits per frame on top of the edge counter and flags the frame end.
module uart_rx_bit_timer
  import uart_rx_bit_timer_pkg::*;
#(
  parameter int PRESCALE_W   = 6,
  parameter int BIT_CNT_W    = 4,
  parameter int MIN_PRESCALE = MIN_PRESCALE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_rx_bit_timer_if.slave  bus
);

  localparam logic [PRESCALE_W-1:0] PE_MIN = PRESCALE_W'(MIN_PRESCALE);

  frame_cfg_t            cfg_sh;
  logic [PRESCALE_W-1:0] pe_sh;
  logic [PRESCALE_W-1:0] pe_req;
  logic [PRESCALE_W-1:0] pe_eff;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BIT_CNT_W-1:0]  fl;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic                  capture;
  logic                  last_bit;
  logic                  bit_done;
  logic                  sample_stb;
  logic                  mid_stb;

  // Capture window is idle or the very first edge of a frame; pe_eff also
  // guards the zeroed shadow seen right after reset.
  always_comb begin
    capture  = ~bus.enable | ((bit_cnt == BIT_CNT_W'(0)) & (edge_cnt == PRESCALE_W'(0)));
    pe_req   = (bus.prescale < PE_MIN) ? PE_MIN : bus.prescale;
    pe_eff   = (pe_sh < PE_MIN) ? PE_MIN : pe_sh;
    fl       = BIT_CNT_W'(frame_len(cfg_sh.par_en, cfg_sh.data_len, cfg_sh.stop2));
    last_bit = (bit_cnt == (fl - BIT_CNT_W'(1)));
  end

  // Configuration shadow registers, frozen for the rest of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_sh <= '0;
      pe_sh  <= '0;
    end else if (capture) begin
      cfg_sh <= '{par_en: bus.par_en, data_len: bus.data_len, stop2: bus.stop2};
      pe_sh  <= pe_req;
    end
  end

  uart_edge_counter #(
    .PRESCALE_W (PRESCALE_W)
  ) u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (bus.enable),
    .pe         (pe_eff),
    .edge_cnt   (edge_cnt),
    .bit_done   (bit_done),
    .sample_stb (sample_stb),
    .mid_stb    (mid_stb)
  );

  // Bit counter: advances on each bit end and wraps straight into the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (!bus.enable) begin
      bit_cnt <= '0;
    end else if (bit_done) begin
      bit_cnt <= last_bit ? BIT_CNT_W'(0) : (bit_cnt + BIT_CNT_W'(1));
    end
  end

  assign bus.bit_cnt    = bit_cnt;
  assign bus.edge_cnt   = edge_cnt;
  assign bus.sample_stb = sample_stb;
  assign bus.mid_stb    = mid_stb;
  assign bus.bit_done   = bit_done;
  assign bus.frame_done = bit_done & last_bit;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Scoreboard bench for uart_rx_bit_timer: a behavioural model queues the
// expected outputs for every driven cycle, a negedge monitor compares them.
module tb_uart_rx_bit_timer;

  localparam int PW = 6;
  localparam int BW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_bit_timer_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus ();

  uart_rx_bit_timer #(
    .PRESCALE_W   (PW),
    .BIT_CNT_W    (BW),
    .MIN_PRESCALE (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int m_bit = 0, m_edge = 0;
  int s_par = 0, s_len = 0, s_st2 = 0, s_pe = 0;

  logic [13:0] sb[$];
  int drive_cnt = 0, fd_count = 0, fd_last = 0;

  function automatic int pe_of(input int p);
    return (p < 4) ? 4 : p;
  endfunction

  function automatic int fl_of();
    return 1 + 5 + s_len + s_par + (s_st2 != 0 ? 2 : 1);
  endfunction

  function automatic logic [13:0] expect_now(input logic en);
    int   pe, h, fl;
    logic ss, ms, bd, fd;
    pe = pe_of(s_pe);
    h  = pe / 2;
    fl = fl_of();
    ss = en && (m_edge == h - 1 || m_edge == h || m_edge == h + 1);
    ms = en && (m_edge == h);
    bd = en && (m_edge == pe - 1);
    fd = bd && (m_bit == fl - 1);
    return {4'(m_bit), 6'(m_edge), ss, ms, bd, fd};
  endfunction

  task automatic drive(input logic en, input logic par, input logic [1:0] len,
                       input logic st2, input logic [5:0] pre);
    bit cap;
    int pe, fl;
    bus.enable   = en;
    bus.par_en   = par;
    bus.data_len = len;
    bus.stop2    = st2;
    bus.prescale = pre;
    drive_cnt++;
    sb.push_back(expect_now(en));
    @(posedge clk);
    cap = !en || (m_bit == 0 && m_edge == 0);
    pe  = pe_of(s_pe);
    fl  = fl_of();
    if (!en) begin
      m_bit  = 0;
      m_edge = 0;
    end else if (m_edge == pe - 1) begin
      m_edge = 0;
      m_bit  = (m_bit == fl - 1) ? 0 : m_bit + 1;
    end else begin
      m_edge++;
    end
    if (cap) begin
      s_par = par;
      s_len = len;
      s_st2 = st2;
      s_pe  = pe_of(int'(pre));
    end
    #1;
  endtask

  task automatic run(input int n, input logic en, input logic par, input logic [1:0] len,
                     input logic st2, input logic [5:0] pre);
    for (int i = 0; i < n; i++) drive(en, par, len, st2, pre);
  endtask

  task automatic clear_stats();
    drive_cnt = 0;
    fd_count  = 0;
    fd_last   = 0;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [13:0] exp;
      exp = sb.pop_front();
      check("cycle", {bus.bit_cnt, bus.edge_cnt, bus.sample_stb, bus.mid_stb,
                      bus.bit_done, bus.frame_done}, exp);
      if (bus.frame_done) begin
        fd_count++;
        fd_last = drive_cnt;
      end
    end
  end

  initial begin
    bus.enable   = 1'b0;
    bus.par_en   = 1'b0;
    bus.data_len = 2'd3;
    bus.stop2    = 1'b0;
    bus.prescale = 6'd8;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {bus.bit_cnt, bus.edge_cnt, bus.sample_stb, bus.mid_stb,
                          bus.bit_done, bus.frame_done}, 32'd0);
    rst_n = 1'b1;

    // 1: P=8, 8N1
    run(2, 1'b0, 1'b0, 2'd3, 1'b0, 6'd8);
    clear_stats();
    run(81, 1'b1, 1'b0, 2'd3, 1'b0, 6'd8);
    check("t1_fd_count", 32'(fd_count), 32'd1);
    check("t1_fd_cycle", 32'(fd_last), 32'd80);

    // 2: P=16, 8E2
    run(2, 1'b0, 1'b1, 2'd3, 1'b1, 6'd16);
    clear_stats();
    run(193, 1'b1, 1'b1, 2'd3, 1'b1, 6'd16);
    check("t2_fd_count", 32'(fd_count), 32'd1);
    check("t2_fd_cycle", 32'(fd_last), 32'd192);

    // 3: parity enabled mid-frame only affects the following frame
    run(2, 1'b0, 1'b0, 2'd3, 1'b0, 6'd8);
    clear_stats();
    run(32, 1'b1, 1'b0, 2'd3, 1'b0, 6'd8);
    run(137, 1'b1, 1'b1, 2'd3, 1'b0, 6'd8);
    check("t3_fd_count", 32'(fd_count), 32'd2);
    check("t3_fd_cycle", 32'(fd_last), 32'd168);

    // 4: abandon at bit 3 edge 5, then a fresh frame
    run(2, 1'b0, 1'b0, 2'd3, 1'b0, 6'd8);
    clear_stats();
    run(29, 1'b1, 1'b0, 2'd3, 1'b0, 6'd8);
    check("t4_pre_drop", {bus.bit_cnt, bus.edge_cnt}, {4'd3, 6'd5});
    run(2, 1'b0, 1'b0, 2'd3, 1'b0, 6'd8);
    check("t4_cleared", {bus.bit_cnt, bus.edge_cnt}, 32'd0);
    check("t4_no_fd", 32'(fd_count), 32'd0);
    clear_stats();
    run(81, 1'b1, 1'b0, 2'd3, 1'b0, 6'd8);
    check("t4_refd_cycle", 32'(fd_last), 32'd80);

    // 5: prescale 2 clamps to 4, then async reset mid-frame
    run(2, 1'b0, 1'b0, 2'd3, 1'b0, 6'd2);
    clear_stats();
    run(51, 1'b1, 1'b0, 2'd3, 1'b0, 6'd2);
    check("t5_fd_cycle", 32'(fd_last), 32'd40);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_rst", {bus.bit_cnt, bus.edge_cnt, bus.sample_stb, bus.mid_stb,
                           bus.bit_done, bus.frame_done}, 32'd0);
    m_bit = 0; m_edge = 0; s_par = 0; s_len = 0; s_st2 = 0; s_pe = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_stats();
    run(41, 1'b1, 1'b0, 2'd3, 1'b0, 6'd2);
    check("t5_post_rst_fd", 32'(fd_last), 32'd40);

    // 6: P=32, 5N1, three frames back to back
    run(2, 1'b0, 1'b0, 2'd0, 1'b0, 6'd32);
    clear_stats();
    run(673, 1'b1, 1'b0, 2'd0, 1'b0, 6'd32);
    check("t6_fd_count", 32'(fd_count), 32'd3);
    check("t6_fd_cycle", 32'(fd_last), 32'd672);

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
